// File: rtl/mem_port_arbiter.sv
// Shares one processor-to-memory port between the instruction-fetch and data-cache controllers.
// It tracks which requester owns each outstanding load tag and steers returning data to that owner.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int NTAGS      = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,

  input  logic [1:0]        Dmem_command,
  input  logic [ADDR_W-1:0] Dmem_addr,
  input  logic [1:0]        Dmem_size,
  input  logic [63:0]       Dmem_data,
  output logic [3:0]        dmem_response,
  output logic [3:0]        dmem_tag,
  output logic [63:0]       dmem_data,

  input  logic [1:0]        Imem_command,
  input  logic [ADDR_W-1:0] Imem_addr,
  output logic [3:0]        imem_response,
  output logic [3:0]        imem_tag,
  output logic [63:0]       imem_data,

  output logic [1:0]        proc2mem_command,
  output logic [ADDR_W-1:0] proc2mem_addr,
  output logic [1:0]        proc2mem_size,
  output logic [63:0]       proc2mem_data,
  input  logic [3:0]        mem2proc_response,
  input  logic [3:0]        mem2proc_tag,
  input  logic [63:0]       mem2proc_data,

  output logic              tag_err
);

  localparam int              SW          = $clog2(STARVE_MAX + 1);
  localparam logic [1:0]      CMD_NONE    = 2'd0;
  localparam logic [1:0]      CMD_LOAD    = 2'd1;
  localparam logic [1:0]      SIZE_DOUBLE = 2'b11;
  localparam logic [SW-1:0]   STARVE_LIM  = SW'(STARVE_MAX);

  logic [NTAGS-1:0] valid_q, valid_d;
  logic [NTAGS-1:0] owner_q, owner_d;   // 0 = Dmem, 1 = Imem
  logic [SW-1:0]    starve_q, starve_d;
  logic             tag_err_q, tag_err_d;

  logic dmem_req, imem_req;
  logic grant_imem, grant_dmem;
  logic alloc;
  logic ret_hit, ret_miss, ret_owner;

  always_comb begin
    dmem_req   = (Dmem_command != CMD_NONE);
    imem_req   = (Imem_command != CMD_NONE);
    grant_imem = imem_req && (!dmem_req || (starve_q == STARVE_LIM));
    grant_dmem = dmem_req && !grant_imem;
  end

  always_comb begin
    proc2mem_command = CMD_NONE;
    proc2mem_addr    = '0;
    proc2mem_size    = '0;
    proc2mem_data    = '0;
    if (grant_imem) begin
      proc2mem_command = Imem_command;
      proc2mem_addr    = Imem_addr;
      proc2mem_size    = SIZE_DOUBLE;
    end else if (grant_dmem) begin
      proc2mem_command = Dmem_command;
      proc2mem_addr    = Dmem_addr;
      proc2mem_size    = Dmem_size;
      proc2mem_data    = Dmem_data;
    end
    dmem_response = grant_dmem ? mem2proc_response : 4'd0;
    imem_response = grant_imem ? mem2proc_response : 4'd0;
    alloc         = (proc2mem_command == CMD_LOAD) && (mem2proc_response != 4'd0);
  end

  // Return routing uses the owner recorded before this cycle's allocation.
  always_comb begin
    ret_hit   = (mem2proc_tag != 4'd0) && valid_q[mem2proc_tag];
    ret_miss  = (mem2proc_tag != 4'd0) && !valid_q[mem2proc_tag];
    ret_owner = owner_q[mem2proc_tag];
    dmem_tag  = (ret_hit && !ret_owner) ? mem2proc_tag  : 4'd0;
    dmem_data = (ret_hit && !ret_owner) ? mem2proc_data : 64'd0;
    imem_tag  = (ret_hit &&  ret_owner) ? mem2proc_tag  : 4'd0;
    imem_data = (ret_hit &&  ret_owner) ? mem2proc_data : 64'd0;
  end

  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    if (ret_hit) begin
      valid_d[mem2proc_tag] = 1'b0;
    end
    // A tag re-issued in the same cycle it returns ends up owned by the new requester.
    if (alloc) begin
      valid_d[mem2proc_response] = 1'b1;
      owner_d[mem2proc_response] = grant_imem;
    end
    tag_err_d = tag_err_q | ret_miss;
  end

  always_comb begin
    starve_d = starve_q;
    if (imem_req && !grant_imem) begin
      if (starve_q != STARVE_LIM) begin
        starve_d = starve_q + SW'(1);
      end
    end else if (grant_imem && (mem2proc_response != 4'd0)) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= '0;
      owner_q   <= '0;
      starve_q  <= '0;
      tag_err_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      tag_err_q <= tag_err_d;
    end
  end

  assign tag_err = tag_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant priority, starvation override, tag ownership and reset.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  Dmem_command;
  logic [15:0] Dmem_addr;
  logic [1:0]  Dmem_size;
  logic [63:0] Dmem_data;
  logic [3:0]  dmem_response, dmem_tag;
  logic [63:0] dmem_data;
  logic [1:0]  Imem_command;
  logic [15:0] Imem_addr;
  logic [3:0]  imem_response, imem_tag;
  logic [63:0] imem_data;
  logic [1:0]  proc2mem_command, proc2mem_size;
  logic [15:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [63:0] mem2proc_data;
  logic        tag_err;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.ADDR_W(16), .NTAGS(16), .STARVE_MAX(4)) dut (
    .clock(clock), .reset(reset),
    .Dmem_command(Dmem_command), .Dmem_addr(Dmem_addr), .Dmem_size(Dmem_size), .Dmem_data(Dmem_data),
    .dmem_response(dmem_response), .dmem_tag(dmem_tag), .dmem_data(dmem_data),
    .Imem_command(Imem_command), .Imem_addr(Imem_addr),
    .imem_response(imem_response), .imem_tag(imem_tag), .imem_data(imem_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_size(proc2mem_size), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag), .mem2proc_data(mem2proc_data),
    .tag_err(tag_err)
  );

  always #5 clock = ~clock;

  task automatic idle();
    Dmem_command = 2'd0; Dmem_addr = '0; Dmem_size = '0; Dmem_data = '0;
    Imem_command = 2'd0; Imem_addr = '0;
    mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    tests++; if (proc2mem_command !== 2'd0) begin fails++; $display("FAIL reset.cmd got %0d exp 0", proc2mem_command); end
    tests++; if (proc2mem_addr !== 16'd0) begin fails++; $display("FAIL reset.addr got %h exp 0", proc2mem_addr); end
    tests++; if ({dmem_response, imem_response} !== 8'd0) begin fails++; $display("FAIL reset.resp got %h exp 00", {dmem_response, imem_response}); end
    tests++; if ({dmem_tag, imem_tag} !== 8'd0) begin fails++; $display("FAIL reset.tags got %h exp 00", {dmem_tag, imem_tag}); end
    tests++; if (tag_err !== 1'b0) begin fails++; $display("FAIL reset.tag_err got %b exp 0", tag_err); end
  endtask

  task automatic test_imem_alone();
    idle();
    Imem_command = 2'd1; Imem_addr = 16'h0100; mem2proc_response = 4'd3;
    #1;
    tests++; if (imem_response !== 4'd3) begin fails++; $display("FAIL imem_alone.imem_resp got %0d exp 3", imem_response); end
    tests++; if (dmem_response !== 4'd0) begin fails++; $display("FAIL imem_alone.dmem_resp got %0d exp 0", dmem_response); end
    tests++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 16'h0100) begin fails++; $display("FAIL imem_alone.port got cmd %0d addr %h exp 1 0100", proc2mem_command, proc2mem_addr); end
    tests++; if (proc2mem_size !== 2'b11 || proc2mem_data !== 64'd0) begin fails++; $display("FAIL imem_alone.size_data got %b %h exp 11 0", proc2mem_size, proc2mem_data); end
    tick();
    idle();
    tick();
    mem2proc_tag = 4'd3; mem2proc_data = 64'hDEADBEEF;
    #1;
    tests++; if (imem_tag !== 4'd3 || imem_data !== 64'hDEADBEEF) begin fails++; $display("FAIL imem_alone.ret got %0d %h exp 3 deadbeef", imem_tag, imem_data); end
    tests++; if (dmem_tag !== 4'd0 || dmem_data !== 64'd0) begin fails++; $display("FAIL imem_alone.other got %0d %h exp 0 0", dmem_tag, dmem_data); end
    tick();
    idle();
    #1;
    tests++; if (tag_err !== 1'b0) begin fails++; $display("FAIL imem_alone.tag_err got %b exp 0", tag_err); end
  endtask

  task automatic test_both();
    idle();
    Dmem_command = 2'd1; Dmem_addr = 16'h2000; Dmem_size = 2'd1;
    Imem_command = 2'd1; Imem_addr = 16'h0300; mem2proc_response = 4'd5;
    #1;
    tests++; if (proc2mem_addr !== 16'h2000 || proc2mem_size !== 2'd1) begin fails++; $display("FAIL both.port got %h %0d exp 2000 1", proc2mem_addr, proc2mem_size); end
    tests++; if (dmem_response !== 4'd5 || imem_response !== 4'd0) begin fails++; $display("FAIL both.resp got d%0d i%0d exp d5 i0", dmem_response, imem_response); end
    tick();
    idle();
    #1;
    tests++; if (dut.starve_q !== 3'd1) begin fails++; $display("FAIL both.starve got %0d exp 1", dut.starve_q); end
    mem2proc_tag = 4'd5; mem2proc_data = 64'h55;
    #1;
    tests++; if (dmem_tag !== 4'd5 || dmem_data !== 64'h55 || imem_tag !== 4'd0) begin fails++; $display("FAIL both.ret got d%0d %h i%0d exp d5 55 i0", dmem_tag, dmem_data, imem_tag); end
    tick();
    idle();
  endtask

  // Imem expected to win on cycles 5, 10 and 11 (cycle 10 gets a zero response so the counter holds).
  task automatic test_starvation();
    logic exp_imem;
    logic [3:0] resp;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      exp_imem = (c == 5) || (c == 10) || (c == 11);
      resp = (c == 10) ? 4'd0 : 4'(c);
      Dmem_command = 2'd1; Dmem_addr = 16'h2000 + 16'(c); Dmem_size = 2'd1; Dmem_data = 64'hAB;
      Imem_command = 2'd1; Imem_addr = 16'h0100 + 16'(c);
      mem2proc_response = resp;
      #1;
      tests++;
      if (exp_imem) begin
        if (proc2mem_addr !== 16'h0100 + 16'(c) || imem_response !== resp || dmem_response !== 4'd0 || proc2mem_size !== 2'b11 || proc2mem_data !== 64'd0) begin
          fails++; $display("FAIL starve.c%0d got addr %h i%0d d%0d exp imem grant", c, proc2mem_addr, imem_response, dmem_response);
        end
      end else begin
        if (proc2mem_addr !== 16'h2000 + 16'(c) || dmem_response !== resp || imem_response !== 4'd0 || proc2mem_data !== 64'hAB) begin
          fails++; $display("FAIL starve.c%0d got addr %h i%0d d%0d exp dmem grant", c, proc2mem_addr, imem_response, dmem_response);
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_store_no_record();
    do_reset();
    Dmem_command = 2'd2; Dmem_addr = 16'h0040; Dmem_size = 2'd3; Dmem_data = 64'h1234; mem2proc_response = 4'd7;
    #1;
    tests++; if (proc2mem_command !== 2'd2 || proc2mem_data !== 64'h1234 || dmem_response !== 4'd7) begin fails++; $display("FAIL store.port got %0d %h %0d exp 2 1234 7", proc2mem_command, proc2mem_data, dmem_response); end
    tick();
    idle();
    mem2proc_tag = 4'd7; mem2proc_data = 64'h99;
    #1;
    tests++; if (dmem_tag !== 4'd0 || imem_tag !== 4'd0) begin fails++; $display("FAIL store.ret got d%0d i%0d exp 0 0", dmem_tag, imem_tag); end
    tick();
    idle();
    #1;
    tests++; if (tag_err !== 1'b1) begin fails++; $display("FAIL store.tag_err got %b exp 1", tag_err); end
    tick();
    #1;
    tests++; if (tag_err !== 1'b1) begin fails++; $display("FAIL store.sticky got %b exp 1", tag_err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    Dmem_command = 2'd1; Dmem_addr = 16'h0800; Dmem_size = 2'd3; mem2proc_response = 4'd2;
    tick();
    idle();
    Imem_command = 2'd1; Imem_addr = 16'h0120; mem2proc_response = 4'd2;
    mem2proc_tag = 4'd2; mem2proc_data = 64'hAAAA;
    #1;
    tests++; if (dmem_tag !== 4'd2 || dmem_data !== 64'hAAAA || imem_tag !== 4'd0) begin fails++; $display("FAIL b2b.old got d%0d %h i%0d exp d2 aaaa i0", dmem_tag, dmem_data, imem_tag); end
    tests++; if (imem_response !== 4'd2) begin fails++; $display("FAIL b2b.realloc got %0d exp 2", imem_response); end
    tick();
    idle();
    tick();
    mem2proc_tag = 4'd2; mem2proc_data = 64'hBBBB;
    #1;
    tests++; if (imem_tag !== 4'd2 || imem_data !== 64'hBBBB || dmem_tag !== 4'd0) begin fails++; $display("FAIL b2b.new got i%0d %h d%0d exp i2 bbbb d0", imem_tag, imem_data, dmem_tag); end
    tick();
    idle();
    #1;
    tests++; if (tag_err !== 1'b0) begin fails++; $display("FAIL b2b.tag_err got %b exp 0", tag_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    Dmem_command = 2'd1; Dmem_addr = 16'h0900; Imem_command = 2'd1; Imem_addr = 16'h0200; mem2proc_response = 4'd1;
    tick();
    idle();
    Imem_command = 2'd1; Imem_addr = 16'h0210; mem2proc_response = 4'd4;
    tick();
    do_reset();
    #1;
    tests++; if (dut.starve_q !== 3'd0) begin fails++; $display("FAIL rst_mid.starve got %0d exp 0", dut.starve_q); end
    mem2proc_tag = 4'd1; mem2proc_data = 64'h11;
    #1;
    tests++; if (dmem_tag !== 4'd0 || imem_tag !== 4'd0) begin fails++; $display("FAIL rst_mid.ret got d%0d i%0d exp 0 0", dmem_tag, imem_tag); end
    tick();
    idle();
    #1;
    tests++; if (tag_err !== 1'b1) begin fails++; $display("FAIL rst_mid.tag_err got %b exp 1", tag_err); end
  endtask

  initial begin
    test_reset();
    test_imem_alone();
    test_both();
    test_starvation();
    test_store_no_record();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single processor-to-memory port between the instruction-fetch controller (Imem) and the data-cache controller (Dmem command/addr/size/data outputs of DMEM).
- Grants one requester per cycle. Records which requester owns each outstanding load tag. Steers returning mem2proc_tag/data to that owner only.
- Sits between the core top level and the memory model. Both requesters see the standard 0-means-reject response/tag protocol.

Parameters:
- ADDR_W, 16, address width of both requesters and the memory port.
- NTAGS, 16, tag space size; tag 0 is reserved for "none/reject".
- STARVE_MAX, 4, consecutive lost Imem cycles before Imem is forced to win.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- Dmem_command  in  2  0=NONE, 1=LOAD, 2=STORE
- Dmem_addr  in  ADDR_W  Dmem address
- Dmem_size  in  2  access size
- Dmem_data  in  64  store data
- dmem_response  out  4  tag accepted for Dmem; 0=rejected or not granted
- dmem_tag  out  4  returning tag owned by Dmem; 0=none
- dmem_data  out  64  returning load data for dmem_tag
- Imem_command  in  2  0=NONE, 1=LOAD (STORE never issued)
- Imem_addr  in  ADDR_W  fetch address
- imem_response  out  4  tag accepted for Imem
- imem_tag  out  4  returning tag owned by Imem
- imem_data  out  64  returning data for imem_tag
- proc2mem_command  out  2  granted command
- proc2mem_addr  out  ADDR_W  granted address
- proc2mem_size  out  2  granted size (Imem always 2'b11 DOUBLE)
- proc2mem_data  out  64  granted store data (0 for Imem)
- mem2proc_response  in  4  memory accept tag, same-cycle as command
- mem2proc_tag  in  4  completing tag
- mem2proc_data  in  64  completing data
- tag_err  out  1  sticky: a returning tag had no recorded owner

Behaviour:
- Grant is combinational.
  - Dmem wins by default when both request (command != NONE).
  - Imem wins when starve_cnt == STARVE_MAX.
  - A lone requester always wins.
  - No request drives proc2mem_command=NONE; addr, size and data are 0.
- Response routing: mem2proc_response goes only to the granted requester's *_response; the loser sees 0. A requester seeing 0 must re-present its command next cycle; the arbiter holds no request state.
- Owner table: NTAGS entries, each {valid, owner}; owner 0=Dmem, 1=Imem.
  - Write at posedge when a LOAD is granted and mem2proc_response != 0.
  - Granted STOREs are not recorded.
- Return path, when mem2proc_tag != 0:
  - Valid entry: drive *_tag and *_data of the owner; the other side sees tag 0 and data 0. Clear the entry at posedge.
  - Invalid entry: drive both sides with tag 0 and set tag_err.
- Same tag returning and re-issued in one cycle: the return is routed using the old owner; the new allocation wins the table write, so the entry ends valid with the new owner.
- starve_cnt (width $clog2(STARVE_MAX+1)):
  - +1 when Imem requests and is not granted.
  - Cleared when Imem is granted with a nonzero response.
  - Holds otherwise.
  - Saturates at STARVE_MAX.
- Reset:
  - Table cleared, starve_cnt=0, tag_err=0.
  - All outputs are combinational of inputs and state; with no requests they are all 0.
  - Reset mid-operation discards outstanding ownership; later tag returns then set tag_err.

Test Plan:
- Imem LOAD 0x0100 alone, mem response 3 → imem_response=3, dmem_response=0. Later mem2proc_tag=3, data=0xDEADBEEF → imem_tag=3, imem_data=0xDEADBEEF, dmem_tag=0.
- Both request, Dmem LOAD 0x2000, response 5 → proc2mem_addr=0x2000, dmem_response=5, imem_response=0, starve_cnt=1.
- Dmem and Imem request continuously for 5 cycles, all responses nonzero → cycles 1–4 grant Dmem, cycle 5 grants Imem, starve_cnt returns to 0.
- Dmem STORE, response 7, then mem2proc_tag=7 → dmem_tag=0, imem_tag=0, tag_err=1.
- Tag 2 owned by Dmem returns while a new Imem LOAD gets response 2 → dmem_tag=2 that cycle; the next return of tag 2 goes to imem_tag.
- Reset asserted with tags 1 and 4 outstanding, then tag 1 returns → both *_tag=0, tag_err=1, starve_cnt=0.
